// File: rtl/axi_pkg.sv
// Shared AXI-Lite constants and bridge FSM state encoding.
package axi_pkg;

   localparam int unsigned AXI_ADDR_BITS = 32;
   localparam int unsigned AXI_DATA_BITS = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Bridge FSM state; plain localparams keep the encoding visible to legacy tools.
   typedef logic [2:0] state_t;
   localparam state_t StIdle  = 3'd0;
   localparam state_t StRdAr  = 3'd1;
   localparam state_t StRdR   = 3'd2;
   localparam state_t StWrAww = 3'd3;
   localparam state_t StWrB   = 3'd4;
   localparam state_t StRsp   = 3'd5;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding bridge from a simple core request port to an AXI-Lite master.
// All AXI outputs come straight from state or registers, never from READY inputs.
module axi_lite_master_bridge
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_W = AXI_ADDR_BITS,
   parameter int unsigned DATA_W = AXI_DATA_BITS
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   // core side
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [DATA_W/8-1:0]   req_wstrb_i,
   input  logic [DATA_W-1:0]     req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_W-1:0]     rsp_rdata_o,
   output logic                  rsp_err_o,
   // AXI-Lite read
   output logic [ADDR_W-1:0]     ARADDR,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [DATA_W-1:0]     RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RVALID,
   output logic                  RREADY,
   // AXI-Lite write
   output logic [ADDR_W-1:0]     AWADDR,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [DATA_W-1:0]     WDATA,
   output logic [DATA_W/8-1:0]   WSTRB,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY
);

   localparam int unsigned STRB_W = DATA_W / 8;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                aw_hit, w_hit;

   // Next-state logic: one transaction at a time, request captured only in idle.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      aw_hit    = aw_done_q | AWREADY;
      w_hit     = w_done_q | WREADY;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               wstrb_d = req_wstrb_i;
               state_d = req_we_i ? StWrAww : StRdAr;
            end
         end
         StRdAr: begin
            if (ARREADY) state_d = StRdR;
         end
         StRdR: begin
            if (RVALID) begin
               rdata_d = RDATA;
               err_d   = (RRESP != RESP_OKAY);
               state_d = StRsp;
            end
         end
         StWrAww: begin
            // AW and W may complete in any order; each VALID retires on its own.
            if (aw_hit && w_hit) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = StWrB;
            end else begin
               aw_done_d = aw_hit;
               w_done_d  = w_hit;
            end
         end
         StWrB: begin
            if (BVALID) begin
               err_d   = (BRESP != RESP_OKAY);
               state_d = StRsp;
            end
         end
         StRsp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign req_ready_o = (state_q == StIdle);
   assign rsp_valid_o = (state_q == StRsp);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

   assign ARADDR  = addr_q;
   assign ARVALID = (state_q == StRdAr);
   assign RREADY  = (state_q == StRdR);
   assign AWADDR  = addr_q;
   assign AWVALID = (state_q == StWrAww) && !aw_done_q;
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;
   assign WVALID  = (state_q == StWrAww) && !w_done_q;
   assign BREADY  = (state_q == StWrB);

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: the bench plays both core and AXI-Lite slave,
// stepping one cycle at a time on the falling edge and predicting each output.
module tb_axi_lite_master_bridge;
   import axi_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        req_valid_i, req_ready_o, req_we_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [3:0]  req_wstrb_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [1:0]  RRESP, BRESP;
   logic [3:0]  WSTRB;

   int n_chk = 0;
   int n_pass = 0;
   int ar_hs = 0;
   int rsp_pulses = 0;

   // Reference model: what the core should see after each completion.
   logic [31:0] model_rdata = 32'h0;
   logic        model_err = 1'b0;

   axi_lite_master_bridge dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wstrb_i(req_wstrb_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   always #5 ACLK = ~ACLK;

   // Count AR handshakes and completion pulses as seen on the bus.
   always @(posedge ACLK) begin
      if (ARVALID && ARREADY) ar_hs <= ar_hs + 1;
      if (rsp_valid_o) rsp_pulses <= rsp_pulses + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   // Starts and ends on a falling edge with the bridge idle.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int ar_wait, input int r_wait,
                          input bit keep);
      int p0;
      p0 = rsp_pulses;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = addr;
      req_wdata_i = $urandom; req_wstrb_i = 4'($urandom);
      n_chk++;
      if (req_ready_o !== 1'b1) $display("FAIL rd_req_ready got=%b exp=1", req_ready_o);
      else n_pass++;
      @(negedge ACLK);
      if (!keep) req_valid_i = 1'b0;
      for (int i = 0; i <= ar_wait; i++) begin
         n_chk++;
         if ({ARVALID, ARADDR, RREADY, req_ready_o, rsp_valid_o} !== {1'b1, addr, 3'b000})
            $display("FAIL rd_ar got=%b/%h/%b/%b/%b exp=1/%h/0/0/0",
                     ARVALID, ARADDR, RREADY, req_ready_o, rsp_valid_o, addr);
         else n_pass++;
         if (i == ar_wait) ARREADY = 1'b1;
         @(negedge ACLK);
      end
      ARREADY = 1'b0;
      for (int i = 0; i <= r_wait; i++) begin
         n_chk++;
         if ({ARVALID, RREADY, req_ready_o, rsp_valid_o} !== 4'b0100)
            $display("FAIL rd_r got=%b/%b/%b/%b exp=0/1/0/0",
                     ARVALID, RREADY, req_ready_o, rsp_valid_o);
         else n_pass++;
         if (i == r_wait) begin RVALID = 1'b1; RDATA = data; RRESP = resp; end
         @(negedge ACLK);
      end
      RVALID = 1'b0; RDATA = $urandom; RRESP = 2'($urandom);
      model_rdata = data;
      model_err = (resp != RESP_OKAY);
      n_chk++;
      if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, RREADY} !== {1'b1, model_rdata, model_err, 1'b0})
         $display("FAIL rd_rsp got=%b/%h/%b/%b exp=1/%h/%b/0",
                  rsp_valid_o, rsp_rdata_o, rsp_err_o, RREADY, model_rdata, model_err);
      else n_pass++;
      @(negedge ACLK);
      n_chk++;
      if ({rsp_valid_o, req_ready_o} !== 2'b01 || rsp_pulses - p0 != 1)
         $display("FAIL rd_done got=%b/%b/%0d exp=0/1/1", rsp_valid_o, req_ready_o,
                  rsp_pulses - p0);
      else n_pass++;
   endtask

   // Write with independent AW/W ready timing; abort asserts reset during the B wait.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_wait, input int w_wait,
                           input int b_wait, input logic [1:0] resp, input bit abort);
      int  p0;
      int  c;
      bit  awd;
      bit  wd;
      p0 = rsp_pulses;
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = addr;
      req_wdata_i = data; req_wstrb_i = strb;
      n_chk++;
      if (req_ready_o !== 1'b1) $display("FAIL wr_req_ready got=%b exp=1", req_ready_o);
      else n_pass++;
      @(negedge ACLK);
      req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
      awd = 1'b0; wd = 1'b0; c = 0;
      while (!(awd && wd)) begin
         n_chk++;
         if ({AWVALID, WVALID, AWADDR, WDATA, WSTRB, BREADY, rsp_valid_o, req_ready_o} !==
             {!awd, !wd, addr, data, strb, 3'b000})
            $display("FAIL wr_aww c=%0d got=%b/%b/%h/%h/%h/%b exp=%b/%b/%h/%h/%h/0", c,
                     AWVALID, WVALID, AWADDR, WDATA, WSTRB, BREADY,
                     !awd, !wd, addr, data, strb);
         else n_pass++;
         AWREADY = (c == aw_wait);
         WREADY  = (c == w_wait);
         @(negedge ACLK);
         if (AWREADY) awd = 1'b1;
         if (WREADY) wd = 1'b1;
         AWREADY = 1'b0; WREADY = 1'b0;
         c++;
      end
      for (int i = 0; i <= b_wait; i++) begin
         n_chk++;
         if ({AWVALID, WVALID, BREADY, rsp_valid_o} !== 4'b0010)
            $display("FAIL wr_b got=%b/%b/%b/%b exp=0/0/1/0",
                     AWVALID, WVALID, BREADY, rsp_valid_o);
         else n_pass++;
         if (abort) begin
            #2 ARESETn = 1'b0;
            #1;
            model_rdata = 32'h0;
            model_err = 1'b0;
            n_chk++;
            if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid_o, rsp_err_o} !== 7'b0)
               $display("FAIL rst_ctrl got=%b%b%b%b%b%b%b exp=0000000", ARVALID, AWVALID,
                        WVALID, RREADY, BREADY, rsp_valid_o, rsp_err_o);
            else n_pass++;
            n_chk++;
            if ({rsp_rdata_o, ARADDR, AWADDR, WDATA, WSTRB} !== {model_rdata, 100'h0})
               $display("FAIL rst_data got=%h/%h/%h/%h/%h exp=0", rsp_rdata_o, ARADDR,
                        AWADDR, WDATA, WSTRB);
            else n_pass++;
            repeat (2) @(negedge ACLK);
            ARESETn = 1'b1;
            repeat (3) @(negedge ACLK);
            n_chk++;
            if (rsp_pulses != p0 || req_ready_o !== 1'b1)
               $display("FAIL rst_norsp got=%0d/%b exp=0/1", rsp_pulses - p0, req_ready_o);
            else n_pass++;
            return;
         end
         if (i == b_wait) begin BVALID = 1'b1; BRESP = resp; end
         @(negedge ACLK);
      end
      BVALID = 1'b0; BRESP = 2'($urandom);
      model_err = (resp != RESP_OKAY);
      n_chk++;
      if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, BREADY} !== {1'b1, model_rdata, model_err, 1'b0})
         $display("FAIL wr_rsp got=%b/%h/%b/%b exp=1/%h/%b/0",
                  rsp_valid_o, rsp_rdata_o, rsp_err_o, BREADY, model_rdata, model_err);
      else n_pass++;
      @(negedge ACLK);
      n_chk++;
      if ({rsp_valid_o, req_ready_o} !== 2'b01 || rsp_pulses - p0 != 1)
         $display("FAIL wr_done got=%b/%b/%0d exp=0/1/1", rsp_valid_o, req_ready_o,
                  rsp_pulses - p0);
      else n_pass++;
   endtask

   task automatic test_reset();
      ARESETn = 1'b0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
      req_wstrb_i = '0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
      repeat (3) @(negedge ACLK);
      n_chk++;
      if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid_o, rsp_err_o} !== 7'b0 ||
          {rsp_rdata_o, ARADDR, AWADDR, WDATA, WSTRB} !== 132'h0)
         $display("FAIL reset_vals got=%b%b%b%b%b%b%b/%h/%h exp=0", ARVALID, AWVALID, WVALID,
                  RREADY, BREADY, rsp_valid_o, rsp_err_o, rsp_rdata_o, ARADDR);
      else n_pass++;
      ARESETn = 1'b1;
      @(negedge ACLK);
      n_chk++;
      if (req_ready_o !== 1'b1 || rsp_pulses != 0)
         $display("FAIL reset_ready got=%b/%0d exp=1/0", req_ready_o, rsp_pulses);
      else n_pass++;
   endtask

   task automatic test_read_basic();
      do_read(32'h0000_0010, 32'hDEAD_BEEF, RESP_OKAY, 0, 0, 1'b0);
   endtask

   task automatic test_write_aw_first();
      do_write(32'h0000_0020, 32'h1234_5678, 4'b0011, 0, 2, 0, RESP_OKAY, 1'b0);
   endtask

   task automatic test_read_err();
      do_read(32'h0000_0040, 32'hBAD0_0001, RESP_SLVERR, 1, 0, 1'b0);
      do_read(32'h0000_0044, 32'h0BAD_F00D, RESP_OKAY, 0, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int a0;
      a0 = ar_hs;
      for (int k = 0; k < 3; k++)
         do_read(32'h100 + 32'(k * 4), $urandom, RESP_OKAY, 0, k, 1'b1);
      req_valid_i = 1'b0;
      repeat (3) @(negedge ACLK);
      n_chk++;
      if (ar_hs - a0 != 3 || ARVALID !== 1'b0)
         $display("FAIL b2b_ar_count got=%0d/%b exp=3/0", ar_hs - a0, ARVALID);
      else n_pass++;
   endtask

   task automatic test_reset_in_wr_b();
      do_write(32'h0000_0080, 32'hCAFE_0000, 4'b1111, 1, 0, 3, RESP_OKAY, 1'b1);
      do_read(32'h0000_0084, 32'h5555_AAAA, RESP_OKAY, 0, 0, 1'b0);
   endtask

   task automatic test_r_stall();
      do_read(32'h0000_00C0, 32'h0123_4567, RESP_OKAY, 0, 10, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(1) == 1)
            do_write($urandom, $urandom, 4'($urandom), $urandom_range(3), $urandom_range(3),
                     $urandom_range(3), 2'($urandom), 1'b0);
         else
            do_read($urandom, $urandom, 2'($urandom), $urandom_range(3), $urandom_range(4),
                    1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_aw_first();
      test_read_err();
      test_back_to_back();
      test_reset_in_wr_b();
      test_r_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
